// File: rtl/io_sequencer_pkg.sv
// Shared control definitions for the IN/OUT instruction sequencer:
// FSM state encoding and the default button debounce length.
package io_sequencer_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE             = 3'd0;
    localparam state_t S_IN_WAIT_PRESS    = 3'd1;
    localparam state_t S_IN_WAIT_RELEASE  = 3'd2;
    localparam state_t S_IN_COMMIT        = 3'd3;
    localparam state_t S_OUT_WAIT_PRESS   = 3'd4;
    localparam state_t S_OUT_WAIT_RELEASE = 3'd5;
    localparam state_t S_RESUME           = 3'd6;

endpackage

// File: rtl/io_sequencer_debouncer.sv
// Raw button -> 2-flop synchronizer -> stable-count debouncer.
// pressed pulses for one cycle on the first clean-high cycle.
module button_debouncer
    import io_sequencer_pkg::*;
#(
    parameter int CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic pressed
);

    localparam int CW = $clog2(CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          fire;

    // Last of CYCLES consecutive samples that disagree with level
    assign fire = (sync2 != level) && (cnt == CW'(CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            pressed <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            pressed <= fire && sync2;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (fire) begin
                cnt   <= '0;
                level <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/io_sequencer.sv
// Stalls the CPU across IN/OUT instructions, handshaking with the
// operator through debounced confirm/continue buttons.
module io_sequencer
    import io_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int SWITCH_WIDTH    = 16,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    is_input,
    input  logic                    is_output,
    input  logic                    is_os,
    input  logic                    confirmation,
    input  logic                    continue_button,
    input  logic [SWITCH_WIDTH-1:0] switches,
    input  logic [DATA_WIDTH-1:0]   out_value,
    output logic                    enable,
    output logic [DATA_WIDTH-1:0]   input_data,
    output logic                    input_write,
    output logic [DATA_WIDTH-1:0]   display_value,
    output logic                    busy
);

    state_t                  state_q;
    state_t                  next_state;
    logic                    rst_done;
    logic                    conf_level;
    logic                    conf_pressed;
    logic                    cont_level;
    logic                    cont_pressed;
    logic                    accept_out;
    logic                    enter_commit;
    logic [DATA_WIDTH-1:0]   input_data_q;
    logic [DATA_WIDTH-1:0]   display_q;
    logic                    display_valid;
    logic                    input_write_q;

    button_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_conf_db (
        .clock   (clock),
        .reset   (reset),
        .raw     (confirmation),
        .level   (conf_level),
        .pressed (conf_pressed)
    );

    button_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_cont_db (
        .clock   (clock),
        .reset   (reset),
        .raw     (continue_button),
        .level   (cont_level),
        .pressed (cont_pressed)
    );

    always_comb begin
        next_state = state_q;
        case (state_q)
            S_IDLE: begin
                unique case (1'b1)
                    is_input:
                        next_state = S_IN_WAIT_PRESS;
                    !is_input && is_output && !is_os:
                        next_state = S_OUT_WAIT_PRESS;
                    !is_input && is_output && is_os:
                        next_state = S_RESUME;
                    default:
                        next_state = S_IDLE;
                endcase
            end
            // Press edges only, so a button already held at request time waits
            S_IN_WAIT_PRESS:
                if (conf_pressed) next_state = S_IN_WAIT_RELEASE;
            S_IN_WAIT_RELEASE:
                if (!conf_level) next_state = S_IN_COMMIT;
            S_IN_COMMIT:
                next_state = S_RESUME;
            S_OUT_WAIT_PRESS:
                if (cont_pressed) next_state = S_OUT_WAIT_RELEASE;
            S_OUT_WAIT_RELEASE:
                if (!cont_level) next_state = S_RESUME;
            S_RESUME:
                next_state = S_IDLE;
            default:
                next_state = S_IDLE;
        endcase
    end

    assign accept_out   = (state_q == S_IDLE) && !is_input && is_output;
    assign enter_commit = (state_q == S_IN_WAIT_RELEASE) && !conf_level;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            rst_done      <= 1'b0;
            input_data_q  <= '0;
            input_write_q <= 1'b0;
            display_q     <= '0;
            display_valid <= 1'b0;
        end else begin
            state_q       <= next_state;
            rst_done      <= 1'b1;
            input_write_q <= enter_commit;
            // Data and strobe both land on the IN_COMMIT cycle
            if (enter_commit) begin
                input_data_q <= DATA_WIDTH'(switches);
            end
            if (accept_out) begin
                display_q     <= out_value;
                display_valid <= 1'b1;
            end
        end
    end

    assign enable = rst_done &&
                    (((state_q == S_IDLE) && !is_input && !is_output) ||
                     (state_q == S_RESUME));

    assign busy          = (state_q != S_IDLE);
    assign input_data    = input_data_q;
    assign input_write   = input_write_q;
    assign display_value = display_valid ? display_q : '0;

endmodule

// File: tb/tb_io_sequencer.sv
// Scenario bench for io_sequencer with a short debounce length.
// Expected register writes are queued and popped when input_write fires.
module tb_io_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        is_input = 1'b0;
    logic        is_output = 1'b0;
    logic        is_os = 1'b0;
    logic        confirmation = 1'b0;
    logic        continue_button = 1'b0;
    logic [15:0] switches = '0;
    logic [31:0] out_value = '0;
    logic        enable;
    logic [31:0] input_data;
    logic        input_write;
    logic [31:0] display_value;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    int en_cnt = 0;
    int wr_cnt = 0;
    logic [31:0] exp_wr[$];

    io_sequencer #(
        .DATA_WIDTH      (32),
        .SWITCH_WIDTH    (16),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .is_input        (is_input),
        .is_output       (is_output),
        .is_os           (is_os),
        .confirmation    (confirmation),
        .continue_button (continue_button),
        .switches        (switches),
        .out_value       (out_value),
        .enable          (enable),
        .input_data      (input_data),
        .input_write     (input_write),
        .display_value   (display_value),
        .busy            (busy)
    );

    always #5 clock = ~clock;

    // Advance to the next falling edge and account for enable/write activity
    task automatic step();
        logic [31:0] e;
        @(negedge clock);
        if (enable === 1'b1) en_cnt++;
        if (input_write === 1'b1) begin
            wr_cnt++;
            vectors++;
            if (exp_wr.size() == 0) begin
                miscompares++;
                $display("FAIL write_unexpected: input_data=%h, required no write",
                         input_data);
            end else begin
                e = exp_wr.pop_front();
                if (input_data !== e) begin
                    miscompares++;
                    $display("FAIL write_data: got %h, required %h", input_data, e);
                end
            end
        end
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic push_btn(input bit cont, input int hi, input int lo);
        if (cont) continue_button = 1'b1;
        else confirmation = 1'b1;
        steps(hi);
        continue_button = 1'b0;
        confirmation = 1'b0;
        steps(lo);
    endtask

    task automatic wait_enable(input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            step();
            if (enable === 1'b1) hit = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        steps(2);
        vectors++;
        if (enable !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_enable: got %b, required 0", enable);
        end
        vectors++;
        if ({busy, input_write} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_flags: busy/write got %b, required 00",
                     {busy, input_write});
        end
        vectors++;
        if (input_data !== 32'h0 || display_value !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data: in=%h disp=%h, required 0/0",
                     input_data, display_value);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (enable !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_enable: got %b, required 0", enable);
        end
        step();
        vectors++;
        if (enable !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_enable: got %b, required 1", enable);
        end
    endtask

    task automatic test_input();
        bit hit;
        en_cnt = 0;
        wr_cnt = 0;
        is_input = 1'b1;
        switches = 16'hA5A5;
        exp_wr.push_back(32'h0000A5A5);
        #1;
        vectors++;
        if (enable !== 1'b0) begin
            miscompares++;
            $display("FAIL in_request_enable: got %b, required 0", enable);
        end
        step();
        push_btn(1'b0, 6, 6);
        wait_enable(30, hit);
        is_input = 1'b0;
        switches = 16'h0000;
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL in_timeout: enable got 0, required 1 within 30 cycles");
        end
        vectors++;
        if (en_cnt !== 1 || wr_cnt !== 1) begin
            miscompares++;
            $display("FAIL in_pulses: enable=%0d write=%0d, required 1/1",
                     en_cnt, wr_cnt);
        end
        step();
        vectors++;
        if (enable !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL in_return_idle: en/busy got %b%b, required 10",
                     enable, busy);
        end
        vectors++;
        if (input_data !== 32'h0000A5A5) begin
            miscompares++;
            $display("FAIL in_data_hold: got %h, required 0000a5a5", input_data);
        end
    endtask

    task automatic test_output_user();
        bit hit;
        en_cnt = 0;
        wr_cnt = 0;
        is_output = 1'b1;
        is_os = 1'b0;
        out_value = 32'hDEADBEEF;
        #1;
        vectors++;
        if (enable !== 1'b0) begin
            miscompares++;
            $display("FAIL out_request_enable: got %b, required 0", enable);
        end
        step();
        out_value = 32'h0;
        vectors++;
        if (display_value !== 32'hDEADBEEF || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL out_display: got %h busy=%b, required deadbeef busy=1",
                     display_value, busy);
        end
        steps(8);
        vectors++;
        if (en_cnt !== 0) begin
            miscompares++;
            $display("FAIL out_stall: enable count got %0d, required 0", en_cnt);
        end
        push_btn(1'b1, 6, 6);
        wait_enable(30, hit);
        is_output = 1'b0;
        vectors++;
        if (!hit || en_cnt !== 1 || wr_cnt !== 0) begin
            miscompares++;
            $display("FAIL out_resume: hit=%b en=%0d wr=%0d, required 1/1/0",
                     hit, en_cnt, wr_cnt);
        end
        step();
        vectors++;
        if (display_value !== 32'hDEADBEEF || enable !== 1'b1) begin
            miscompares++;
            $display("FAIL out_hold: got %h en=%b, required deadbeef en=1",
                     display_value, enable);
        end
    endtask

    task automatic test_output_os();
        is_output = 1'b1;
        is_os = 1'b1;
        out_value = 32'h12345678;
        #1;
        vectors++;
        if (enable !== 1'b0) begin
            miscompares++;
            $display("FAIL os_request_enable: got %b, required 0", enable);
        end
        step();
        is_output = 1'b0;
        is_os = 1'b0;
        vectors++;
        if (enable !== 1'b1 || display_value !== 32'h12345678) begin
            miscompares++;
            $display("FAIL os_resume: en=%b disp=%h, required 1 12345678",
                     enable, display_value);
        end
        step();
        vectors++;
        if (enable !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL os_idle: en/busy got %b%b, required 10", enable, busy);
        end
    endtask

    task automatic test_glitch();
        bit hit;
        en_cnt = 0;
        wr_cnt = 0;
        is_input = 1'b1;
        switches = 16'h1234;
        exp_wr.push_back(32'h00001234);
        step();
        push_btn(1'b0, 3, 10);
        push_btn(1'b1, 6, 10);
        vectors++;
        if (busy !== 1'b1 || en_cnt !== 0 || wr_cnt !== 0) begin
            miscompares++;
            $display("FAIL glitch_ignored: busy=%b en=%0d wr=%0d, required 1/0/0",
                     busy, en_cnt, wr_cnt);
        end
        push_btn(1'b0, 6, 6);
        wait_enable(30, hit);
        is_input = 1'b0;
        vectors++;
        if (!hit || wr_cnt !== 1) begin
            miscompares++;
            $display("FAIL glitch_commit: hit=%b wr=%0d, required 1/1", hit, wr_cnt);
        end
        step();
    endtask

    task automatic test_held_button();
        bit hit;
        confirmation = 1'b1;
        steps(8);
        en_cnt = 0;
        wr_cnt = 0;
        is_input = 1'b1;
        switches = 16'h0F0F;
        exp_wr.push_back(32'h00000F0F);
        steps(4);
        confirmation = 1'b0;
        steps(10);
        vectors++;
        if (busy !== 1'b1 || wr_cnt !== 0) begin
            miscompares++;
            $display("FAIL held_button: busy=%b wr=%0d, required 1/0", busy, wr_cnt);
        end
        push_btn(1'b0, 6, 6);
        wait_enable(30, hit);
        is_input = 1'b0;
        vectors++;
        if (!hit || wr_cnt !== 1 || input_data !== 32'h00000F0F) begin
            miscompares++;
            $display("FAIL held_commit: hit=%b wr=%0d data=%h, required 1/1/00000f0f",
                     hit, wr_cnt, input_data);
        end
        step();
    endtask

    task automatic test_both();
        bit hit;
        wr_cnt = 0;
        is_input = 1'b1;
        is_output = 1'b1;
        out_value = 32'hCAFEF00D;
        switches = 16'h5A5A;
        exp_wr.push_back(32'h00005A5A);
        step();
        push_btn(1'b0, 6, 6);
        wait_enable(30, hit);
        is_input = 1'b0;
        is_output = 1'b0;
        vectors++;
        if (!hit || wr_cnt !== 1 || input_data !== 32'h00005A5A) begin
            miscompares++;
            $display("FAIL both_input: hit=%b wr=%0d data=%h, required 1/1/00005a5a",
                     hit, wr_cnt, input_data);
        end
        vectors++;
        if (display_value !== 32'h12345678) begin
            miscompares++;
            $display("FAIL both_display: got %h, required 12345678", display_value);
        end
        step();
    endtask

    task automatic test_reset_mid();
        wr_cnt = 0;
        is_input = 1'b1;
        switches = 16'hFFFF;
        step();
        confirmation = 1'b1;
        steps(8);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({enable, busy, input_write} !== 3'b000) begin
            miscompares++;
            $display("FAIL midreset_flags: en/busy/wr got %b, required 000",
                     {enable, busy, input_write});
        end
        vectors++;
        if (input_data !== 32'h0 || display_value !== 32'h0) begin
            miscompares++;
            $display("FAIL midreset_data: in=%h disp=%h, required 0/0",
                     input_data, display_value);
        end
        confirmation = 1'b0;
        steps(3);
        reset = 1'b1;
        steps(12);
        vectors++;
        if (wr_cnt !== 0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_no_write: wr=%0d busy=%b, required 0/1",
                     wr_cnt, busy);
        end
        is_input = 1'b0;
        reset = 1'b0;
        steps(2);
        reset = 1'b1;
        steps(2);
        vectors++;
        if (enable !== 1'b1 || exp_wr.size() !== 0) begin
            miscompares++;
            $display("FAIL final_state: en=%b pending=%0d, required 1/0",
                     enable, exp_wr.size());
        end
    endtask

    initial begin
        test_reset();
        test_input();
        test_output_user();
        test_output_os();
        test_glitch();
        test_held_button();
        test_both();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/io_sequencer.md
IO_SEQUENCER -- requirements
Module: io_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the register/display word width.
REQ-002 SHALL have parameter SWITCH_WIDTH, default 16, the board switch bank width (≤ DATA_WIDTH).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 250000, the stable-sample count required to accept a button level change.
REQ-004 SHALL have port clock, input, 1, the single clock for the block; all flops on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-006 SHALL have port is_input, input, 1, decoded IN instruction present, held while the instruction is current.
REQ-007 SHALL have port is_output, input, 1, decoded OUT instruction present, held while the instruction is current.
REQ-008 SHALL have port is_os, input, 1, OS-mode flag from the special register.
REQ-009 SHALL have port confirmation, input, 1, raw asynchronous button, active-high, that accepts input.
REQ-010 SHALL have port continue_button, input, 1, raw asynchronous button, active-high, that acknowledges output.
REQ-011 SHALL have port switches, input, SWITCH_WIDTH, raw switch bank value.
REQ-012 SHALL have port out_value, input, DATA_WIDTH, register value to display.
REQ-013 SHALL have port enable, output, 1, CPU-wide advance enable.
REQ-014 SHALL have port input_data, output, DATA_WIDTH, zero-extended captured switches.
REQ-015 SHALL have port input_write, output, 1, one-cycle register-bank write strobe.
REQ-016 SHALL have port display_value, output, DATA_WIDTH, last displayed value.
REQ-017 SHALL have port busy, output, 1, high whenever state ≠ IDLE.

Function
REQ-018 SHALL pass each button through a 2-flop synchronizer, then a debouncer that changes its clean level only after DEBOUNCE_CYCLES consecutive samples at the new level.
REQ-019 SHALL implement states IDLE, IN_WAIT_PRESS, IN_WAIT_RELEASE, IN_COMMIT, OUT_WAIT_PRESS, OUT_WAIT_RELEASE, RESUME.
REQ-020 SHALL, in IDLE: go to IN_WAIT_PRESS if is_input; else go to OUT_WAIT_PRESS if is_output and !is_os; else go to RESUME if is_output and is_os; else stay. Input has priority when both requests are high.
REQ-021 SHALL drive enable combinationally high only when (IDLE and !is_input and !is_output) or RESUME; low in every other case, including the IDLE cycle in which a request is first seen.
REQ-022 SHALL latch display_value ← out_value and set display_valid on the IDLE cycle that accepts an output request, in both OS and user mode.
REQ-023 SHALL move IN_WAIT_PRESS→IN_WAIT_RELEASE on clean confirmation high, and IN_WAIT_RELEASE→IN_COMMIT on clean confirmation low.
REQ-024 SHALL, in IN_COMMIT, capture input_data ← zero-extended switches, assert input_write for exactly that cycle, and go to RESUME.
REQ-025 SHALL move OUT_WAIT_PRESS→OUT_WAIT_RELEASE on clean continue_button high, and OUT_WAIT_RELEASE→RESUME on clean continue_button low.
REQ-026 SHALL spend exactly one cycle in RESUME, with enable high, then return to IDLE.
REQ-027 SHALL ignore the button that does not belong to the current wait state.
REQ-028 SHALL hold a button already clean-high at request time in WAIT_PRESS until a full release and re-press is seen (press-edge qualified).
REQ-029 SHALL hold input_data and display_value stable between updates.

Reset
REQ-030 SHALL, on reset low at any time including mid-sequence, go immediately to IDLE and clear synchronizers, debounce counters, clean levels, input_data, display_value, display_valid and input_write.
REQ-031 SHALL hold enable low while reset is asserted, and drive it per REQ-021 from the first clock after release.

Structure
REQ-032 SHALL place the state encoding and the default DEBOUNCE_CYCLES in a shared control package.
REQ-033 SHALL instantiate one sub-module, button_debouncer (synchronizer plus counter), twice.

Verification (DEBOUNCE_CYCLES=4)
REQ-034 SHALL cover: is_input=1, switches=16'hA5A5, confirmation pressed 6 cycles then released 6 cycles -> enable low throughout, input_write single pulse with input_data=32'h0000A5A5, one RESUME enable pulse.
REQ-035 SHALL cover: is_output=1, is_os=0, out_value=32'hDEADBEEF -> display_value=DEADBEEF next cycle, enable low until continue_button press+release, then one enable pulse.
REQ-036 SHALL cover: is_output=1, is_os=1 -> display updated and enable high again within 2 cycles with no button activity.
REQ-037 SHALL cover: confirmation glitch high for 3 cycles during IN_WAIT_PRESS -> no state change, no input_write.
REQ-038 SHALL cover: reset asserted in IN_WAIT_RELEASE -> IDLE and all outputs 0 without a clock edge, and no input_write after release.
REQ-039 SHALL cover: is_input=is_output=1 -> input sequence taken and display_value unchanged.
